i2c_reader_axil_regfile: RTL
============================

# i2c_reader_axil_regfile

AXI4-Lite slave register file for the I2C reader IP: a parametrised register block with NUM_CTRL_REGS byte-strobed read/write control registers, a read-only status register and a sample FIFO. The I2C read engine pushes captured words into the FIFO. The processing system pops them through a memory-mapped DATA register. A threshold interrupt is raised when the FIFO fill level reaches a programmed value.

## Interface
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, AXI byte-address width; requires NUM_CTRL_REGS+2 <= 2^(C_S_AXI_ADDR_WIDTH-2).
- NUM_CTRL_REGS, 8, number of R/W control registers (>=1).
- FIFO_DEPTH, 16, sample FIFO depth; power of two, 2..256.
- SAMPLE_WIDTH, 16, I2C sample width (<=32); zero-extended on read.
- S_AXI_ACLK  in  1  single clock; everything is synchronous to its rising edge.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR_WIDTH/3/1/1  write-address channel; AWPROT is ignored.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write-data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write-response channel.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR_WIDTH/3/1/1  read-address channel; ARPROT is ignored.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read-data channel.
- smp_valid  in  1  a sample from the I2C engine is present this cycle.
- smp_data  in  SAMPLE_WIDTH  sample word.
- ctrl_out  out  NUM_CTRL_REGS*32  flattened control registers; register k is at [32k+31:32k].
- irq  out  1  level-sensitive threshold interrupt.

## Operation
- Word index = AxADDR[ADDR_WIDTH-1:2]; the low two address bits are ignored.
- Index 0..NUM_CTRL_REGS-1: CTRL[k], R/W, byte-strobed with WSTRB.
- Index NUM_CTRL_REGS: STATUS.
  - Read-only, except bit2, which is write-1-to-clear.
  - Bit0 = empty, bit1 = full, bit2 = overflow (sticky).
  - Bits[15:8] = fill level (8 bits, saturating at 255). Other bits read as 0.
- Index NUM_CTRL_REGS+1: DATA. A read pops the FIFO head. Writes are ignored and return OKAY.
- Indices above NUM_CTRL_REGS+1: writes are ignored, reads return 0, and both respond SLVERR (2'b10). All other responses are OKAY (2'b00).
- Push: when smp_valid=1 and the FIFO is not full, the sample is written at the tail.
- If smp_valid=1 while the FIFO is full, the sample is dropped and overflow is set.
- Pop: a read of DATA that is accepted while the FIFO is non-empty returns the head and removes it.
- A DATA read while the FIFO is empty returns 0, leaves FIFO state unchanged and responds OKAY.
- Simultaneous push and pop on a non-empty FIFO: level is unchanged.
  - Full/empty flags are evaluated on the pre-cycle level, so a push while full is dropped even if a pop happens in the same cycle.
- Overflow clear: a STATUS write with WDATA[2]=1 and WSTRB[0]=1 clears the flag.
  - If an overflowing push occurs in the same cycle, set wins.
- irq = CTRL[0][31] & (level >= CTRL[0][7:0]).
  - A threshold of 0 with enable set holds irq high continuously.
- Pointers wrap modulo FIFO_DEPTH. Level is a ($clog2(FIFO_DEPTH)+1)-bit count from 0 to FIFO_DEPTH.

## Timing
- Reset values:
  - AWREADY, WREADY, ARREADY, BVALID, RVALID and irq are 0.
  - BRESP, RRESP and RDATA are 0.
  - All CTRL registers are 0. The FIFO is empty and overflow is clear.
- Write handshake: AWREADY and WREADY pulse high together for one cycle (cycle N).
  - Condition: AWVALID=1, WVALID=1 and no write response is pending (BVALID=0).
  - The register is updated at the end of cycle N.
  - BVALID rises in N+1 and holds, with BRESP stable, until BREADY=1.
- Read handshake: ARREADY pulses for one cycle (N) when ARVALID=1 and RVALID=0.
  - RDATA/RRESP are registered at the end of N, so RVALID rises in N+1 and holds until RREADY=1.
  - A FIFO pop takes effect at the end of cycle N, exactly once per accepted read.
- Throughput is at most one write per 2 cycles and one read per 2 cycles. Read and write channels operate independently and concurrently.
- A read of CTRL[k] in the same cycle as a write to CTRL[k] returns the old value.
- irq is registered and lags the level change by one cycle.
- Reset asserted mid-transaction: any pending BVALID/RVALID drops on the next edge and the response is discarded. The master must reissue.

## Test plan
- Reset, then write 0x1,0x2,0x3,0x4 to CTRL[0..3] and read them back -> each read returns the same value with RRESP=0; ctrl_out[127:0]=0x00000004_00000003_00000002_00000001.
- Byte strobe: write 0xAABBCCDD to CTRL[1] with WSTRB=4'b0101 over an old value of 0x11223344 -> readback is 0x11BB33DD.
- Push samples 0x0001..0x0010 (16 samples), then read STATUS -> 0x00001002 (level 16, full). Then push 0x0011 -> STATUS reads 0x00001006 (overflow set). Sixteen DATA reads return 0x1..0x10 in order; a 17th returns 0 with STATUS=0x00000005.
- Write STATUS with WDATA=0x4 -> bit2 clears. In a second run, assert an overflowing push in the same cycle as the clear -> bit2 remains 1.
- Set CTRL[0]=0x80000003, push 2 samples -> irq stays 0. Push a 3rd -> irq=1 one cycle later. One DATA read -> irq returns to 0.
- Read word index 15 with default parameters -> RDATA=0 and RRESP=2'b10. Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and their payloads stay stable. Assert reset while RVALID=1 -> RVALID=0 on the next cycle.

Source files
------------

// File: rtl/i2c_reader_axil_regfile_if.sv
// AXI4-Lite bus bundle between the processing system and the I2C reader register block.
interface i2c_reader_axil_regfile_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/i2c_reader_axil_regfile.sv
// AXI4-Lite register file for the I2C reader: control registers, FIFO status,
// a pop-on-read sample FIFO fed by the I2C engine, and a fill-level threshold interrupt.
module i2c_reader_axil_regfile #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_CTRL_REGS      = 8,
    parameter int FIFO_DEPTH         = 16,
    parameter int SAMPLE_WIDTH       = 16
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    i2c_reader_axil_regfile_if.slave      s_axi,
    input  logic                          smp_valid,
    input  logic [SAMPLE_WIDTH-1:0]       smp_data,
    output logic [NUM_CTRL_REGS*32-1:0]   ctrl_out,
    output logic                          irq
);
    localparam int IDX_W      = C_S_AXI_ADDR_WIDTH - 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int LVL_W      = PTR_W + 1;
    localparam int STATUS_IDX = NUM_CTRL_REGS;
    localparam int DATA_IDX   = NUM_CTRL_REGS + 1;

    logic                          r_awready;
    logic                          r_arready;
    logic                          r_bvalid;
    logic                          r_rvalid;
    logic [1:0]                    r_bresp;
    logic [1:0]                    r_rresp;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
    logic [31:0]                   r_ctrl [NUM_CTRL_REGS];
    logic [SAMPLE_WIDTH-1:0]       r_mem  [FIFO_DEPTH];
    logic [PTR_W-1:0]              r_wr_ptr;
    logic [PTR_W-1:0]              r_rd_ptr;
    logic [LVL_W-1:0]              r_level;
    logic                          r_ovf;
    logic                          r_irq;

    logic [IDX_W-1:0]              w_wr_idx;
    logic [IDX_W-1:0]              w_rd_idx;
    int                            w_wr_i;
    int                            w_rd_i;
    logic                          w_wr_en;
    logic                          w_rd_en;
    logic                          w_full;
    logic                          w_empty;
    logic                          w_push;
    logic                          w_drop;
    logic                          w_pop;
    logic                          w_ovf_clr;
    logic [1:0]                    w_wr_resp;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_rd_data;
    logic [1:0]                    w_rd_resp;
    logic [31:0]                   w_status;
    logic                          w_unused;

    // Fill level reported in STATUS is 8 bits wide; a 256-deep FIFO saturates at 255.
    function automatic logic [7:0] sat_fill(input logic [LVL_W-1:0] lvl);
        logic [31:0] wide;
        wide = 32'(lvl);
        return (wide > 32'd255) ? 8'hFF : wide[7:0];
    endfunction

    assign w_wr_idx  = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_rd_idx  = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_wr_i    = int'(w_wr_idx);
    assign w_rd_i    = int'(w_rd_idx);

    assign w_wr_en   = r_awready & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
    assign w_rd_en   = r_arready & s_axi.S_AXI_ARVALID;

    assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_push    = smp_valid & ~w_full;
    assign w_drop    = smp_valid & w_full;
    assign w_pop     = w_rd_en & (w_rd_i == DATA_IDX) & ~w_empty;
    assign w_ovf_clr = w_wr_en & (w_wr_i == STATUS_IDX) & s_axi.S_AXI_WSTRB[0] & s_axi.S_AXI_WDATA[2];
    assign w_wr_resp = (w_wr_i > DATA_IDX) ? 2'b10 : 2'b00;

    assign w_status  = {16'h0000, sat_fill(r_level), 5'b00000, r_ovf, w_full, w_empty};

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = 2'b00;
        if (w_rd_i < NUM_CTRL_REGS) begin
            for (int k = 0; k < NUM_CTRL_REGS; k++) begin
                if (w_rd_i == k) w_rd_data = r_ctrl[k];
            end
        end else if (w_rd_i == STATUS_IDX) begin
            w_rd_data = w_status;
        end else if (w_rd_i == DATA_IDX) begin
            if (!w_empty) w_rd_data = 32'(r_mem[r_rd_ptr]);
        end else begin
            w_rd_resp = 2'b10;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_awready <= 1'b0;
            r_arready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_rresp   <= 2'b00;
            r_rdata   <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_ovf     <= 1'b0;
            r_irq     <= 1'b0;
            for (int k = 0; k < NUM_CTRL_REGS; k++) r_ctrl[k] <= '0;
        end else begin
            // Ready pulses for exactly one cycle and stays low while a response is outstanding.
            r_awready <= ~r_awready & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~r_bvalid;
            r_arready <= ~r_arready & s_axi.S_AXI_ARVALID & ~r_rvalid;

            if (w_wr_en) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_resp;
            end else if (s_axi.S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end

            if (w_rd_en) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_resp;
            end else if (s_axi.S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end

            if (w_wr_en) begin
                for (int k = 0; k < NUM_CTRL_REGS; k++) begin
                    if (w_wr_i == k) begin
                        for (int b = 0; b < 4; b++) begin
                            if (s_axi.S_AXI_WSTRB[b]) r_ctrl[k][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
                        end
                    end
                end
            end

            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase

            // A dropped sample in the same cycle as a clear keeps the flag set.
            if (w_drop)         r_ovf <= 1'b1;
            else if (w_ovf_clr) r_ovf <= 1'b0;

            r_irq <= r_ctrl[0][31] & (32'(r_level) >= 32'(r_ctrl[0][7:0]));
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (w_push) r_mem[r_wr_ptr] <= smp_data;
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CTRL_REGS; g++) begin : g_ctrl_out
            assign ctrl_out[32*g +: 32] = r_ctrl[g];
        end
    endgenerate

    assign s_axi.S_AXI_AWREADY = r_awready;
    assign s_axi.S_AXI_WREADY  = r_awready;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = r_bresp;
    assign s_axi.S_AXI_ARREADY = r_arready;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RRESP   = r_rresp;
    assign irq                 = r_irq;

    assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
endmodule
